// File: rtl/regfile_writeback_pkg.sv
// ---------------------------------------------------------------------------
// regfile_writeback_pkg
//   Shared defaults for the write-back slice and the bit layout of one
//   retire-queue entry. An entry is packed LSB-first as
//   {rd, data, dv, ld}: ld at bit 0, dv at bit 1, data above that, rd on top.
// ---------------------------------------------------------------------------
package regfile_writeback_pkg;

    localparam int DEPTH_DEF = 4;   // retire-queue entries (power of two, >= 2)
    localparam int XLEN_DEF  = 32;  // data width
    localparam int RAW_DEF   = 5;   // register index width

    // Entry field offsets
    localparam int F_LD   = 0;      // entry is a load
    localparam int F_DV   = 1;      // data valid
    localparam int F_DATA = 2;      // start of data field

    // rd sits directly above the data field, so its offset depends on XLEN
    function automatic int f_rd(input int xlen);
        return F_DATA + xlen;
    endfunction

    function automatic int entry_w(input int xlen, input int raw);
        return F_DATA + xlen + raw;
    endfunction

endpackage

// File: rtl/wb_retire_queue.sv
// ---------------------------------------------------------------------------
// wb_retire_queue
//   In-order retire queue for completed EX results. Holds ALU results with
//   data and loads awaiting their memory response. Pops the head every cycle
//   its data is valid.
//
//   CLK, RSTN          clock, async active-low reset (pointers/count only)
//   push, push_*       write one entry at the tail (caller gates with ~full)
//   fill, fill_data    load response for the oldest unfilled load
//   full               count == DEPTH
//   fill_hit           an unfilled load exists for a response this cycle
//   pop                head is present with valid data; popped this edge
//   head_rd/head_data  head entry fields
//   wr_ptr, count      tail pointer and occupancy for the forwarding search
//   q_rd/q_data/q_dv   raw view of every slot
// ---------------------------------------------------------------------------
module wb_retire_queue
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW   = RAW_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            push,
    input  logic [RAW-1:0]  push_rd,
    input  logic [XLEN-1:0] push_data,
    input  logic            push_ld,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    output logic            full,
    output logic            fill_hit,
    output logic            pop,
    output logic [RAW-1:0]  head_rd,
    output logic [XLEN-1:0] head_data,
    output logic [PW-1:0]   wr_ptr,
    output logic [CW-1:0]   count,
    output logic [RAW-1:0]  q_rd   [DEPTH],
    output logic [XLEN-1:0] q_data [DEPTH],
    output logic            q_dv   [DEPTH]
);

    localparam int F_RD = f_rd(XLEN);
    localparam int EW   = entry_w(XLEN, RAW);

    logic [EW-1:0] mem [DEPTH];
    logic          q_ld [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] fill_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_rd[i]   = mem[i][F_RD +: RAW];
            q_data[i] = mem[i][F_DATA +: XLEN];
            q_dv[i]   = mem[i][F_DV];
            q_ld[i]   = mem[i][F_LD];
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign pop       = (count != '0) && q_dv[rd_ptr];
    assign head_rd   = q_rd[rd_ptr];
    assign head_data = q_data[rd_ptr];

    // Oldest present load without data. Scanning oldest-last and letting
    // the last match win leaves the entry closest to the head selected.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        fill_hit = 1'b0;
        fill_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count) && q_ld[rd_ptr + PW'(i)] && !q_dv[rd_ptr + PW'(i)]) begin
                fill_hit = 1'b1;
                fill_idx = rd_ptr + PW'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the entry storage has no reset; emptying the queue through the
    // pointers/count is enough because no slot outside count is ever read.
    // Push targets the free tail slot and fill a present slot, so the two
    // writes never collide.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {push_rd, push_data, ~push_ld, push_ld};
        end
        if (fill && fill_hit) begin
            mem[fill_idx][F_DATA +: XLEN] <= fill_data;
            mem[fill_idx][F_DV]           <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//   Write side of the operand register file. Collects EX results (loads are
//   filled later from mem_*), retires them in order onto the write port and
//   produces operand bypass controls plus a load-use stall for decode.
//
//   CLK, RSTN                    clock, async active-low reset
//   ex_valid/ex_ready            EX result handshake
//   ex_rd, ex_data, ex_is_load   EX result (data ignored for loads)
//   mem_valid, mem_data          in-order load responses
//   rd, rd_data, rd_wen          registered register-file write port
//   rs1, rs2                     decode source indices
//   rsN_forward(_data)           bypass select and value per source
//   stall                        a source hits a load still missing data
//   load_err                     sticky: response with no pending load
// ---------------------------------------------------------------------------
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW   = RAW_DEF
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [RAW-1:0]  ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_load,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_data,
    output logic [RAW-1:0]  rd,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_wen,
    input  logic [RAW-1:0]  rs1,
    input  logic [RAW-1:0]  rs2,
    output logic            rs1_forward,
    output logic [XLEN-1:0] rs1_forward_data,
    output logic            rs2_forward,
    output logic [XLEN-1:0] rs2_forward_data,
    output logic            stall,
    output logic            load_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic            full;
    logic            fill_hit;
    logic            pop;
    logic [RAW-1:0]  head_rd;
    logic [XLEN-1:0] head_data;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [RAW-1:0]  q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic            q_dv   [DEPTH];

    assign ex_ready = ~full;

    wb_retire_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RAW(RAW)) u_queue (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .push      (ex_valid & ex_ready),
        .push_rd   (ex_rd),
        .push_data (ex_data),
        .push_ld   (ex_is_load),
        .fill      (mem_valid),
        .fill_data (mem_data),
        .full      (full),
        .fill_hit  (fill_hit),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .wr_ptr    (wr_ptr),
        .count     (count),
        .q_rd      (q_rd),
        .q_data    (q_data),
        .q_dv      (q_dv)
    );

    // Write port: rd/rd_data hold when nothing retires; x0 never writes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd       <= '0;
            rd_data  <= '0;
            rd_wen   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            rd_wen <= pop && (head_rd != '0);
            if (pop) begin
                rd      <= head_rd;
                rd_data <= head_data;
            end
            if (mem_valid && !fill_hit) load_err <= 1'b1;
        end
    end

    // Forwarding search, one per source. Offset i counts back from the
    // youngest entry; iterating from oldest to youngest lets the youngest
    // match overwrite older ones. The write-port fallback covers the value
    // being written on the same edge the register file samples it.
    for (genvar s = 0; s < 2; s++) begin : g_fwd
        logic [RAW-1:0]  src;
        logic            hit;
        logic            fwd;
        logic            stl;
        logic [XLEN-1:0] fdata;
        logic [PW-1:0]   idx;

        assign src = (s == 0) ? rs1 : rs2;

        always_comb begin
            hit   = 1'b0;
            fwd   = 1'b0;
            stl   = 1'b0;
            fdata = '0;
            idx   = '0;
            if (src != '0) begin
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    idx = wr_ptr - PW'(i + 1);
                    if ((CW'(i) < count) && (q_rd[idx] == src)) begin
                        hit   = 1'b1;
                        fwd   = q_dv[idx];
                        stl   = ~q_dv[idx];
                        fdata = q_dv[idx] ? q_data[idx] : '0;
                    end
                end
                if (!hit && rd_wen && (rd == src)) begin
                    fwd   = 1'b1;
                    fdata = rd_data;
                end
            end
        end
    end

    assign rs1_forward      = g_fwd[0].fwd;
    assign rs1_forward_data = g_fwd[0].fdata;
    assign rs2_forward      = g_fwd[1].fwd;
    assign rs2_forward_data = g_fwd[1].fdata;
    assign stall            = g_fwd[0].stl | g_fwd[1].stl;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RSTN;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_is_load;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        rd_wen;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_forward;
    logic [31:0] rs1_forward_data;
    logic        rs2_forward;
    logic [31:0] rs2_forward_data;
    logic        stall;
    logic        load_err;

    regfile_writeback #(.DEPTH(DEPTH), .XLEN(32), .RAW(5)) dut (
        .CLK              (CLK),
        .RSTN             (RSTN),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_rd            (ex_rd),
        .ex_data          (ex_data),
        .ex_is_load       (ex_is_load),
        .mem_valid        (mem_valid),
        .mem_data         (mem_data),
        .rd               (rd),
        .rd_data          (rd_data),
        .rd_wen           (rd_wen),
        .rs1              (rs1),
        .rs2              (rs2),
        .rs1_forward      (rs1_forward),
        .rs1_forward_data (rs1_forward_data),
        .rs2_forward      (rs2_forward),
        .rs2_forward_data (rs2_forward_data),
        .stall            (stall),
        .load_err         (load_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          dv;
        bit          ld;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  m_rd      = '0;
    logic [31:0] m_rd_data = '0;
    bit          m_rd_wen  = 1'b0;
    bit          m_err     = 1'b0;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mq.delete();
            m_rd = '0; m_rd_data = '0; m_rd_wen = 1'b0; m_err = 1'b0;
        end else begin
            bit   do_pop;
            bit   can_push;
            int   fi;
            ent_t head;
            ent_t e;
            do_pop   = (mq.size() > 0) && mq[0].dv;
            can_push = (mq.size() < DEPTH);
            head     = '{rd: '0, data: '0, dv: 1'b0, ld: 1'b0};
            if (do_pop) head = mq[0];
            fi = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (fi < 0 && mq[i].ld && !mq[i].dv) fi = i;
            end
            if (mem_valid) begin
                if (fi >= 0) begin
                    e = mq[fi]; e.data = mem_data; e.dv = 1'b1; mq[fi] = e;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (ex_valid && can_push)
                mq.push_back('{rd: ex_rd, data: ex_data, dv: !ex_is_load, ld: ex_is_load});
            m_rd_wen = do_pop && (head.rd != 0);
            if (do_pop) begin
                m_rd      = head.rd;
                m_rd_data = head.data;
            end
        end
    end

    function automatic void exp_fwd(input logic [4:0] s, output bit f,
                                    output logic [31:0] d, output bit st);
        bit found;
        f = 1'b0; d = '0; st = 1'b0; found = 1'b0;
        if (s != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!found && mq[i].rd == s) begin
                    found = 1'b1;
                    if (mq[i].dv) begin f = 1'b1; d = mq[i].data; end
                    else st = 1'b1;
                end
            end
            if (!found && m_rd_wen && m_rd == s) begin f = 1'b1; d = m_rd_data; end
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        bit          f1, f2, s1, s2;
        logic [31:0] d1, d2;
        #2;
        exp_fwd(rs1, f1, d1, s1);
        exp_fwd(rs2, f2, d2, s2);
        check("ex_ready", 32'(ex_ready), 32'(mq.size() < DEPTH));
        check("rd_wen", 32'(rd_wen), 32'(m_rd_wen));
        check("rd", 32'(rd), 32'(m_rd));
        check("rd_data", rd_data, m_rd_data);
        check("load_err", 32'(load_err), 32'(m_err));
        check("rs1_forward", 32'(rs1_forward), 32'(f1));
        check("rs1_forward_data", rs1_forward_data, d1);
        check("rs2_forward", 32'(rs2_forward), 32'(f2));
        check("rs2_forward_data", rs2_forward_data, d2);
        check("stall", 32'(stall), 32'(s1 | s2));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic ld, input logic mv, input logic [31:0] md,
                         input logic [4:0] a, input logic [4:0] b);
        @(negedge CLK);
        ex_valid = v; ex_rd = r; ex_data = d; ex_is_load = ld;
        mem_valid = mv; mem_data = md; rs1 = a; rs2 = b;
        #3;
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b);
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, a, b);
    endtask

    initial begin
        RSTN = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_data = '0; ex_is_load = 1'b0;
        mem_valid = 1'b0; mem_data = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge CLK);
        #3;
        check("reset rd_wen", 32'(rd_wen), 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset load_err", 32'(load_err), 32'd0);
        check("reset ex_ready", 32'(ex_ready), 32'd1);
        @(negedge CLK);
        RSTN = 1'b1;

        // 1: ALU result, forward then retire
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, '0, 5'd0, 5'd0);
        idle(5'd5, 5'd0);
        check("t1 rs1_forward", 32'(rs1_forward), 32'd1);
        check("t1 rs1_forward_data", rs1_forward_data, 32'h1234);
        idle(5'd5, 5'd0);
        check("t1 rd_wen", 32'(rd_wen), 32'd1);
        check("t1 rd", 32'(rd), 32'd5);
        check("t1 rd_data", rd_data, 32'h1234);
        idle(5'd0, 5'd0);
        check("t1 rd_wen low", 32'(rd_wen), 32'd0);

        // 2: load-use stall, fill, retire
        drive(1'b1, 5'd7, 32'h0, 1'b1, 1'b0, '0, 5'd0, 5'd7);
        idle(5'd0, 5'd7);
        check("t2 stall", 32'(stall), 32'd1);
        check("t2 rs2_forward", 32'(rs2_forward), 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 5'd7);
        idle(5'd0, 5'd7);
        check("t2 stall clear", 32'(stall), 32'd0);
        check("t2 rs2_forward_data", rs2_forward_data, 32'hDEADBEEF);
        idle(5'd0, 5'd0);
        check("t2 rd_wen", 32'(rd_wen), 32'd1);
        check("t2 rd", 32'(rd), 32'd7);

        // 3: same destination three times, youngest wins, in-order retire
        drive(1'b1, 5'd3, 32'h11, 1'b0, 1'b0, '0, 5'd3, 5'd0);
        drive(1'b1, 5'd3, 32'h22, 1'b0, 1'b0, '0, 5'd3, 5'd0);
        check("t3 fwd 0x11", rs1_forward_data, 32'h11);
        drive(1'b1, 5'd3, 32'h0, 1'b1, 1'b0, '0, 5'd3, 5'd0);
        check("t3 retire 0x11", rd_data, 32'h11);
        check("t3 fwd 0x22", rs1_forward_data, 32'h22);
        idle(5'd3, 5'd0);
        check("t3 retire 0x22", rd_data, 32'h22);
        check("t3 stall", 32'(stall), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h33, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        check("t3 fwd 0x33", rs1_forward_data, 32'h33);
        idle(5'd0, 5'd0);
        check("t3 retire 0x33", rd_data, 32'h33);

        // 4: full queue back-pressure
        for (int i = 0; i < 4; i++) drive(1'b1, 5'(10 + i), 32'h0, 1'b1, 1'b0, '0, 5'd0, 5'd0);
        drive(1'b1, 5'd14, 32'h55, 1'b0, 1'b0, '0, 5'd0, 5'd0);
        check("t4 full", 32'(ex_ready), 32'd0);
        drive(1'b1, 5'd14, 32'h55, 1'b0, 1'b1, 32'hA0, 5'd0, 5'd0);
        check("t4 push ignored", 32'(ex_ready), 32'd0);
        drive(1'b1, 5'd14, 32'h55, 1'b0, 1'b1, 32'hA1, 5'd0, 5'd0);
        check("t4 filled still full", 32'(ex_ready), 32'd0);
        drive(1'b1, 5'd14, 32'h55, 1'b0, 1'b0, '0, 5'd0, 5'd0);
        check("t4 ready after pop", 32'(ex_ready), 32'd1);
        check("t4 retire rd10", rd_data, 32'hA0);
        idle(5'd0, 5'd0);
        check("t4 retire rd11", rd_data, 32'hA1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'hA2, 5'd0, 5'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'hA3, 5'd0, 5'd0);
        repeat (5) idle(5'd0, 5'd0);

        // 5: x0 destination, spurious response
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check("t5 rs1_forward x0", 32'(rs1_forward), 32'd0);
        idle(5'd0, 5'd0);
        check("t5 rd_wen x0", 32'(rd_wen), 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h77, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check("t5 load_err", 32'(load_err), 32'd1);
        idle(5'd0, 5'd0);
        check("t5 load_err sticky", 32'(load_err), 32'd1);

        // 6: reset with entries queued
        for (int i = 0; i < 3; i++) drive(1'b1, 5'(1 + i), 32'h0, 1'b1, 1'b0, '0, 5'd0, 5'd0);
        idle(5'd1, 5'd0);
        check("t6 stall before reset", 32'(stall), 32'd1);
        @(negedge CLK);
        RSTN = 1'b0;
        #3;
        check("t6 rd_wen", 32'(rd_wen), 32'd0);
        check("t6 ex_ready", 32'(ex_ready), 32'd1);
        check("t6 rs1_forward", 32'(rs1_forward), 32'd0);
        check("t6 stall", 32'(stall), 32'd0);
        check("t6 load_err", 32'(load_err), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        drive(1'b1, 5'd9, 32'h99, 1'b0, 1'b0, '0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check("t6 rd_wen after", 32'(rd_wen), 32'd1);
        check("t6 rd after", 32'(rd), 32'd9);
        check("t6 rd_data after", rd_data, 32'h99);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                @(negedge CLK);
                RSTN = 1'b0;
                @(negedge CLK);
                RSTN = 1'b1;
            end
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        idle(5'd0, 5'd0);
        @(negedge CLK);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
